// File: rtl/nes_pad_reader.sv
// NES controller poller: latches the pad, shifts 8 bits over pad_clk, and publishes
// the inverted word with a one-cycle valid strobe and a changed flag.
module nes_pad_reader #(
  parameter int unsigned LATCH_CYCLES = 600,
  parameter int unsigned HALF_CYCLES  = 300,
  parameter int unsigned POLL_CYCLES  = 833333
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       pad_data_n,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       buttons_valid,
  output logic       buttons_changed
);

  localparam int unsigned PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int unsigned CNT_W     = $clog2(PHASE_MAX);
  localparam int unsigned POLL_W    = $clog2(POLL_CYCLES);

  localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    phase_r, phase_s;
  logic [2:0]          idx_r, idx_s;
  logic [7:0]          shift_r, shift_s;
  logic [POLL_W-1:0]   poll_r;
  logic                poll_wrap_s;
  logic                sync1_r, sync2_r;
  logic                latch_r, latch_s;
  logic                clk_r, clk_s;
  logic [7:0]          buttons_r, buttons_s;
  logic                valid_r, valid_s;
  logic                changed_r, changed_s;

  assign poll_wrap_s = (poll_r == POLL_LAST);

  // Next-state and next-output decode for the frame sequencer
  always_comb begin
    state_s   = state_r;
    phase_s   = phase_r;
    idx_s     = idx_r;
    shift_s   = shift_r;
    buttons_s = buttons_r;
    valid_s   = 1'b0;
    changed_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (poll_wrap_s && enable) begin
          state_s = S_LATCH;
          phase_s = {CNT_W{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LATCH: begin
        if (phase_r == LATCH_LAST) begin
          state_s = S_LOW;
          phase_s = {CNT_W{1'b0}};
        end else begin
          phase_s = phase_r + CNT_W'(1);
        end
      end
      S_LOW: begin
        if (phase_r == HALF_LAST) begin
          // Sample at the end of the low half so the pad has settled after its shift
          shift_s[idx_r] = ~sync2_r;
          phase_s        = {CNT_W{1'b0}};
          if (idx_r == 3'd7) begin
            state_s = S_DONE;
          end else begin
            state_s = S_HIGH;
          end
        end else begin
          phase_s = phase_r + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (phase_r == HALF_LAST) begin
          state_s = S_LOW;
          phase_s = {CNT_W{1'b0}};
          idx_s   = idx_r + 3'd1;
        end else begin
          phase_s = phase_r + CNT_W'(1);
        end
      end
      S_DONE: begin
        buttons_s = shift_r;
        valid_s   = 1'b1;
        changed_s = (shift_r != buttons_r);
        idx_s     = 3'd0;
        state_s   = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
        phase_s = {CNT_W{1'b0}};
        idx_s   = 3'd0;
      end
    endcase
    latch_s = (state_s == S_LATCH);
    clk_s   = (state_s == S_HIGH);
  end

  // State, counters, synchronizer and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_r   <= S_IDLE;
      phase_r   <= {CNT_W{1'b0}};
      idx_r     <= 3'd0;
      shift_r   <= 8'h00;
      poll_r    <= {POLL_W{1'b0}};
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      latch_r   <= 1'b0;
      clk_r     <= 1'b0;
      buttons_r <= 8'h00;
      valid_r   <= 1'b0;
      changed_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      phase_r   <= phase_s;
      idx_r     <= idx_s;
      shift_r   <= shift_s;
      poll_r    <= poll_wrap_s ? {POLL_W{1'b0}} : (poll_r + POLL_W'(1));
      sync1_r   <= pad_data_n;
      sync2_r   <= sync1_r;
      latch_r   <= latch_s;
      clk_r     <= clk_s;
      buttons_r <= buttons_s;
      valid_r   <= valid_s;
      changed_r <= changed_s;
    end
  end

  assign pad_latch       = latch_r;
  assign pad_clk         = clk_r;
  assign buttons         = buttons_r;
  assign buttons_valid   = valid_r;
  assign buttons_changed = changed_r;

endmodule
